// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN          address / PC width
//   INSTR_W       instruction word width
//   PC_STEP       byte increment between sequential fetches
//   fetch_entry_t one buffered instruction together with its byte address
package fetch_pkg;
    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Bus interfaces of the fetch stage.
//   imem_if : fetch -> instruction memory request channel plus in-order
//             response return. master = fetch unit, slave = memory.
//   dec_if  : fetch -> decode valid/ready channel carrying {instr, pc}.
//             master = fetch unit, slave = decode.
interface imem_if;
    import fetch_pkg::*;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    modport master (output imem_req_valid, imem_addr,
                    input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
    modport slave  (input  imem_req_valid, imem_addr,
                    output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

interface dec_if;
    import fetch_pkg::*;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [XLEN-1:0]    dec_pc;

    modport master (output dec_valid, dec_instr, dec_pc, input dec_ready);
    modport slave  (input  dec_valid, dec_instr, dec_pc, output dec_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the instruction buffer and
// the pc side-queue.
//   clk, rst_n   clock, async active-low reset
//   push/push_data  write one entry
//   pop          drop the head entry
//   flush        empty the FIFO (wins over push/pop)
//   head         current head entry (storage at the read pointer)
//   count/full/empty occupancy
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0],
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          flush,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty && !flush));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word reads to instruction
// memory under a credit limit of DEPTH (buffered + outstanding), buffers
// in-order responses and hands {instr, pc} to decode. A redirect flushes
// everything and marks in-flight responses to be dropped.
//   clk, reset       clock, async active-low reset
//   imem             request/response channel to instruction memory
//   redirect_valid/redirect_pc  flush and restart fetch
//   dec              valid/ready channel to decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = 64'h0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    imem_if.master          imem,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    dec_if.master           dec
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             SW      = CW + 1;
    localparam logic [SW-1:0]  DEPTH_S = SW'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding, drop;
    logic [CW-1:0]   ibuf_count, pcq_count;
    logic            ibuf_full, ibuf_empty, pcq_full, pcq_empty;
    fetch_entry_t    ibuf_head, ibuf_in;
    logic [XLEN-1:0] pcq_head;
    logic            credit_ok, req_fire, rsp_keep, dec_fire;
    logic [CW-1:0]   rsp_dec;

    assign credit_ok = ({1'b0, ibuf_count} + {1'b0, outstanding}) < DEPTH_S;
    assign imem.imem_req_valid = reset && !redirect_valid && credit_ok;
    assign imem.imem_addr      = pc;
    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_dec  = CW'(imem.imem_rsp_valid);

    // Responses belonging to requests issued before a redirect are dropped
    // until the drop counter drains; a response in the redirect cycle itself
    // is always discarded.
    assign rsp_keep = imem.imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign ibuf_in  = '{instr: imem.imem_rsp_data, pc: pcq_head};

    assign dec.dec_valid = !ibuf_empty && !redirect_valid;
    assign dec.dec_instr = ibuf_head.instr;
    assign dec.dec_pc    = ibuf_head.pc;
    assign dec_fire      = dec.dec_valid && dec.dec_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= {PC_RESET[XLEN-1:2], 2'b00};
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc & ~XLEN'(3);
            outstanding <= outstanding - rsp_dec;
            drop        <= outstanding - rsp_dec;
        end else begin
            if (req_fire) pc <= pc + XLEN'(PC_STEP);
            outstanding <= outstanding + CW'(req_fire) - rsp_dec;
            if (imem.imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_ibuf (
        .clk       (clk),
        .rst_n     (reset),
        .push      (rsp_keep),
        .push_data (ibuf_in),
        .pop       (dec_fire),
        .flush     (redirect_valid),
        .head      (ibuf_head),
        .count     (ibuf_count),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    // Holds the address of every non-dropped outstanding request so the
    // returning word can be tagged with its pc.
    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pcq (
        .clk       (clk),
        .rst_n     (reset),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .head      (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
        (drop <= outstanding) && ({1'b0, outstanding} <= DEPTH_S));
    a_pcq_track: assert property (@(posedge clk) disable iff (!reset)
        (pcq_count <= outstanding) && !(req_fire && pcq_full) && !(rsp_keep && pcq_empty));
    a_full_idle: assert property (@(posedge clk) disable iff (!reset)
        !(ibuf_full && (outstanding != '0)));
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [63:0] PCR   = 64'h100;

    logic        clk = 0;
    logic        reset = 0;
    logic        redirect_valid = 0;
    logic [63:0] redirect_pc = '0;

    imem_if imem ();
    dec_if  dec ();

    fetch_unit #(.PC_RESET(PCR), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec)
    );

    always #5 clk = ~clk;

    // Reference model: queues of outstanding requests and buffered words.
    typedef struct { logic [63:0] pc; bit drop; } out_t;
    typedef struct { logic [63:0] addr; int due; } mreq_t;
    out_t        out_q[$];
    logic [95:0] buf_q[$];   // {instr, pc}
    mreq_t       mem_q[$];   // memory-side view of accepted requests
    logic [63:0] m_pc;
    int cyc = 0;
    int n_chk = 0, n_fail = 0, n_pop = 0;
    int p_dr, p_rr, p_rsp, p_redir, max_lat;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hF800_0000 | a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic cycle(input bit fr, input logic [63:0] fpc);
        bit   e_req, e_dec, req_f, rsp_f, dec_f, redir;
        out_t o;
        @(negedge clk);
        cyc++;
        dec.dec_ready        = ($urandom_range(99) < p_dr);
        imem.imem_req_ready  = ($urandom_range(99) < p_rr);
        redir                = fr || ($urandom_range(99) < p_redir);
        redirect_valid       = redir;
        redirect_pc          = fr ? fpc : {$urandom, $urandom};
        rsp_f = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rsp);
        imem.imem_rsp_valid  = rsp_f;
        imem.imem_rsp_data   = rsp_f ? instr_of(mem_q[0].addr) : $urandom;
        #1;
        e_req = !redir && (buf_q.size() + out_q.size() < DEPTH);
        chk("req_valid", {63'd0, imem.imem_req_valid}, {63'd0, e_req});
        if (e_req) chk("imem_addr", imem.imem_addr, m_pc);
        e_dec = !redir && (buf_q.size() != 0);
        chk("dec_valid", {63'd0, dec.dec_valid}, {63'd0, e_dec});
        if (e_dec) begin
            chk("dec_pc", dec.dec_pc, buf_q[0][63:0]);
            chk("dec_instr", {32'd0, dec.dec_instr}, {32'd0, buf_q[0][95:64]});
        end
        req_f = e_req && imem.imem_req_ready;
        dec_f = e_dec && dec.dec_ready;
        if (req_f) mem_q.push_back('{m_pc, cyc + 1 + int'($urandom_range(max_lat))});
        if (rsp_f) void'(mem_q.pop_front());
        if (redir) begin
            buf_q.delete();
            if (rsp_f) void'(out_q.pop_front());
            foreach (out_q[i]) out_q[i].drop = 1'b1;
            m_pc = {redirect_pc[63:2], 2'b00};
        end else begin
            if (dec_f) begin
                void'(buf_q.pop_front());
                n_pop++;
            end
            if (rsp_f) begin
                o = out_q.pop_front();
                if (!o.drop) buf_q.push_back({imem.imem_rsp_data, o.pc});
            end
            if (req_f) begin
                out_q.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", {63'd0, imem.imem_req_valid}, 64'd0);
        chk("rst_dec_valid", {63'd0, dec.dec_valid}, 64'd0);
        chk("rst_dec_instr", {32'd0, dec.dec_instr}, 64'd0);
        chk("rst_dec_pc", dec.dec_pc, 64'd0);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #1;
        reset               = 0;
        redirect_valid      = 0;
        imem.imem_rsp_valid = 0;
        imem.imem_req_ready = 0;
        dec.dec_ready       = 0;
        #1;
        check_reset_outputs();
        out_q.delete();
        buf_q.delete();
        mem_q.delete();
        m_pc = PCR;
        repeat (ncyc) @(negedge clk);
        reset = 1;
    endtask

    initial begin
        imem.imem_req_ready = 0;
        imem.imem_rsp_valid = 0;
        imem.imem_rsp_data  = '0;
        dec.dec_ready       = 0;
        m_pc = PCR;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        reset = 1;

        // Streaming with everything ready and single-cycle memory.
        p_dr = 100; p_rr = 100; p_rsp = 100; p_redir = 0; max_lat = 0;
        repeat (20) cycle(1'b0, '0);
        // Decode stall, then release.
        p_dr = 0;   repeat (10) cycle(1'b0, '0);
        p_dr = 100; repeat (10) cycle(1'b0, '0);
        // Memory not ready: address must hold.
        p_rr = 0;   repeat (3)  cycle(1'b0, '0);
        p_rr = 100; repeat (10) cycle(1'b0, '0);
        // Redirects: unaligned target, then wrap past the top of memory.
        cycle(1'b1, 64'h2003);
        repeat (10) cycle(1'b0, '0);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (10) cycle(1'b0, '0);
        // Back-to-back redirects.
        max_lat = 2;
        cycle(1'b1, 64'h3000);
        cycle(1'b1, 64'h4001);
        repeat (10) cycle(1'b0, '0);

        // Randomised traffic.
        p_dr = 70; p_rr = 70; p_rsp = 70; p_redir = 5;
        repeat (1500) cycle(1'b0, '0);
        do_reset(2);
        repeat (200) cycle(1'b0, '0);
        p_redir = 30;
        repeat (300) cycle(1'b0, '0);
        p_redir = 0; p_dr = 100; p_rr = 100; p_rsp = 100;
        repeat (20) cycle(1'b0, '0);

        chk("dec_progress", {63'd0, (n_pop > 200)}, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the ARMv8 (LEGv8-subset) core. It owns the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses. It presents {instr, pc} to the decode stage over a valid/ready channel. Decode slices dec_instr and feeds it to the immediate sign-extension unit and the register file. Branch/jump redirects from execute flush in-flight state and restart fetch.

Parameters:
PC_RESET, 64'h0, PC value loaded on reset
DEPTH, 2, instruction buffer entries; also the maximum of (buffered + outstanding) requests; must be ≥1

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_addr  out  64  request byte address (= pc), bits [1:0] always 0
imem_rsp_valid  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  64  new PC; bits [1:0] ignored (forced 0)
dec_valid  out  1  dec_instr/dec_pc valid
dec_ready  in  1  decode accepts head entry
dec_instr  out  32  instruction word to decode/sign-extension
dec_pc  out  64  byte address of dec_instr

Behaviour:
- Reset (reset=0, async): pc=PC_RESET, buffer empty, outstanding=0, drop=0. Outputs imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
- Deassertion: first request is issued the cycle after reset rises; reset mid-operation discards all buffered, outstanding and dropped state.
- Credit rule: imem_req_valid = !redirect_valid && (count + outstanding < DEPTH). count is the buffer occupancy.
- Request handshake (valid&&ready): outstanding += 1; the request's pc is pushed into the pc side-queue (depth DEPTH); pc += 4, wrapping modulo 2^64 (all-ones-minus-3 wraps to 0).
- imem_addr = pc; it is held stable while imem_req_valid=1 and ready=0.
- Response (imem_rsp_valid), drop>0: discard the data; drop -= 1; outstanding -= 1.
- Response, drop==0: push {data, pc-queue head} into the buffer; outstanding -= 1.
- Latency: a response becomes visible at decode the cycle after imem_rsp_valid (registered; no bypass). Minimum request-to-decode latency is 2 cycles.
- dec_valid = (count != 0) && !redirect_valid. dec_instr/dec_pc = buffer head and are stable while dec_valid && !dec_ready.
- Pop occurs on dec_valid&&dec_ready.
- Simultaneous push and pop: count unchanged. Overflow is impossible by the credit rule; a push with count==DEPTH is an assertion failure.
- Redirect (redirect_valid=1), single cycle, highest priority:
  - buffer cleared; pc-queue cleared; pc <= {redirect_pc[63:2], 2'b00}.
  - drop <= outstanding minus any response arriving that same cycle (that response is discarded).
  - No request or pop handshake occurs in the redirect cycle.
  - A new request may issue the following cycle if credits allow.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Invariant: drop ≤ outstanding ≤ DEPTH.

Decomposition:
- Package fetch_pkg: XLEN=64, INSTR_W=32, PC_STEP=4, typedef fetch_entry_t {logic [31:0] instr; logic [63:0] pc;}.
- Sub-module fetch_fifo: parameterised synchronous FIFO (DEPTH, entry type) with push/pop/flush, count, full/empty, and async active-low reset.
- It is instantiated twice: once as the instruction buffer, once as the pc side-queue.

Test Plan:
- Reset with PC_RESET=0x100, imem always ready, 1-cycle response returning 0xF8000000|addr, dec_ready=1 → dec_pc sequence 0x100,0x104,0x108…, one per cycle after 2-cycle startup.
- dec_ready=0 for 10 cycles → at most DEPTH=2 requests issued; dec_instr/dec_pc held stable; no loss after release.
- imem_req_ready=0 for 3 cycles → imem_addr held at 0x108; resumes 0x108 then 0x10C.
- Redirect to 0x2003 with 2 requests outstanding → both responses dropped; next imem_addr=0x2000; next dec_pc=0x2000.
- Redirect in the same cycle as a response and with dec_ready=1 → no dec handshake; response discarded; drop correct.
- Wrap test: PC_RESET=0xFFFF_FFFF_FFFF_FFFC → second request address is 0x0.
- Reset asserted mid-stream with outstanding responses → all outputs 0 immediately; fetch restarts at PC_RESET.
